rob_ctrl: RTL
=============

Name: rob_ctrl

Overview:
- Pointer and status controller for the reorder buffer. Sits between dispatch, writeback and retire on one side and the ROB entry RAM on the other.
- Allocates up to 2 entries per cycle in program order, tracks a per-entry done bit, and retires up to 2 completed entries per cycle from the head.
- Drives the RAM read addresses for the head entries and exposes occupancy, full and empty to dispatch.

Parameters:
- WIDTH, 38, ROB entry width. Entry layout is {value[31:0], done, rd[4:0]}.
- ADDR, 4, entry index width.
- DEPTH, 1<<ADDR, number of entries. Must be a power of two.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush (mispredict/exception)
- disp_req_0  in  1  dispatch slot 0 requests an entry
- disp_req_1  in  1  dispatch slot 1 requests an entry (younger than slot 0)
- disp_grant_0  out  1  slot 0 allocated this cycle
- disp_grant_1  out  1  slot 1 allocated this cycle
- disp_tag_0  out  ADDR  ROB tag for slot 0 (= tail)
- disp_tag_1  out  ADDR  ROB tag for slot 1 (= tail+1 when slot 0 is also granted)
- wb_valid_0, wb_valid_1  in  1 each  writeback results arriving
- wb_tag_0, wb_tag_1  in  ADDR each  tags of the completing entries
- ram_addr_out_0  out  ADDR  = head
- ram_addr_out_1  out  ADDR  = head+1
- ram_o_en_0, ram_o_en_1  out  1 each  tied high whenever not in reset
- ram_data_0, ram_data_1  in  WIDTH each  asynchronous read data for head and head+1
- retire_en  in  1  retire stage accepts commits this cycle
- commit_valid_0, commit_valid_1  out  1 each  entry retires this cycle
- commit_rd_0, commit_rd_1  out  5 each  ram_data_x[4:0]
- commit_value_0, commit_value_1  out  32 each  ram_data_x[37:6]
- count  out  ADDR+1  occupied entries
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset (asynchronous, active-low): head=tail=0, count=0, done vector=0. All grants and commit_valids are 0; empty=1, full=0.
- State: head, tail (ADDR bits, wrap modulo DEPTH), count (ADDR+1 bits), done[DEPTH-1:0]. No FSM beyond these registers.
- Free space is computed from registered count only. Entries freed by a commit are not reusable in the same cycle.
- Dispatch grants (combinational):
  - disp_grant_0 = disp_req_0 && free>=1 && !flush.
  - disp_grant_1 = disp_req_1 && disp_grant_0 && free>=2. Dispatch is in order; slot 1 never allocates alone.
  - A request with disp_req_1=1 and disp_req_0=0 receives no grant.
- Allocation edge: tail += grants. done[tag] is cleared for each granted tag.
- Writeback: wb_valid_x sets done[wb_tag_x] at the next edge. Both ports may target different tags in the same cycle.
  - If a wb tag equals a tag being allocated in the same cycle, allocation wins and done stays 0. This only occurs with a stale tag; the block treats it as a don't-care hazard.
  - Writeback to a non-occupied entry is ignored.
- Commit (combinational from registered state):
  - commit_valid_0 = retire_en && !flush && count>=1 && done[head].
  - commit_valid_1 = commit_valid_0 && count>=2 && done[head+1].
  - A writeback in cycle N makes its entry committable in cycle N+1 at the earliest; there is no same-cycle bypass.
- Commit edge: head += commits, and done bits of committed entries are cleared.
- count_next = count + grants - commits. All three (alloc, wb, commit) can occur in one cycle.
- Wrap-around: head+1 and tail+1 wrap modulo DEPTH. An entry at index DEPTH-1 pairs with index 0.
- Flush: overrides dispatch, writeback and commit in the same cycle. Grants and commit_valids are forced low. Next edge: head=tail=count=0 and done vector=0.
- Reset mid-operation discards all state immediately, with no drain.

Decomposition:
- Shared package (struct.v / constants.vh) holds:
  - rob_entry_t typedef {value[31:0], done, rd[4:0]}.
  - Field bit-position constants ROB_RD_LSB=0, ROB_DONE_BIT=5, ROB_VAL_LSB=6.
  - ROB_ADDR and ROB_WIDTH defaults.
- One natural sub-module: rob_done_vec. It holds the DEPTH-bit done register with 2 set ports (wb), 2 clear ports (alloc) and 2 clear ports (commit), plus the precedence rules above.
- rob_ctrl instantiates rob_done_vec and connects to the existing ROB RAM at top level.

Test Plan (DEPTH=16):
- Reset, then disp_req_0=disp_req_1=1 for 8 cycles -> grants 1/1 each cycle; tags (0,1),(2,3)…(14,15); full=1 and count=16 after cycle 8; cycle 9 grants 0/0.
- Empty ROB, disp_req_0=1 only, then wb_valid_0 with tag 0 next cycle -> commit_valid_0=1 exactly one cycle after wb with rd/value taken from ram_data_0; empty=1 after.
- Tags 0..3 allocated; wb tags 1 and 0 in consecutive cycles -> no commit while done[0]=0; then commit_valid_0=commit_valid_1=1 (entries 0,1) in one cycle; head=2.
- Fill to 15, head=14 via prior commits; dual dispatch at tail=15 -> tags 15,0 (wrap); commit pair at head=15 reads ram_addr_out_1=0.
- count=15 with same-cycle dual request and dual commit -> only grant_0=1 (free=1 pre-commit); count_next=14.
- Mid-stream flush with pending req, wb and committable head -> all grants/commits 0 that cycle; next cycle head=tail=0, count=0, empty=1. Async reset pulse mid-fill -> outputs at reset values immediately.

Source files
------------

// File: rtl/rob_ctrl_pkg.sv
// Shared types and constants for the reorder-buffer controller.
// Entry layout in the ROB RAM is {value[31:0], done, rd[4:0]}.
package rob_ctrl_pkg;

    localparam int ROB_ADDR     = 4;
    localparam int ROB_WIDTH    = 38;
    localparam int ROB_RD_LSB   = 0;
    localparam int ROB_DONE_BIT = 5;
    localparam int ROB_VAL_LSB  = 6;

    typedef struct packed {
        logic [31:0] value;
        logic        done;
        logic [4:0]  rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_done_vec.sv
// Per-entry completion bits: two writeback set ports, two allocation and two
// commit clear ports. Flush beats clears, clears beat sets.
module rob_done_vec
    import rob_ctrl_pkg::*;
#(
    parameter int ADDR  = ROB_ADDR,
    parameter int DEPTH = 1 << ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [1:0]           set_en,
    input  logic [1:0][ADDR-1:0] set_idx,
    input  logic [1:0]           alloc_en,
    input  logic [1:0][ADDR-1:0] alloc_idx,
    input  logic [1:0]           commit_en,
    input  logic [1:0][ADDR-1:0] commit_idx,
    output logic [DEPTH-1:0]     done
);

    logic [DEPTH-1:0] done_reg;
    logic [DEPTH-1:0] done_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
            logic set_hit;
            logic clr_hit;

            assign set_hit = (set_en[0] && set_idx[0] == ADDR'(gi)) ||
                             (set_en[1] && set_idx[1] == ADDR'(gi));
            // A freshly allocated tag must start not-done even if a stale writeback hits it.
            assign clr_hit = (alloc_en[0]  && alloc_idx[0]  == ADDR'(gi)) ||
                             (alloc_en[1]  && alloc_idx[1]  == ADDR'(gi)) ||
                             (commit_en[0] && commit_idx[0] == ADDR'(gi)) ||
                             (commit_en[1] && commit_idx[1] == ADDR'(gi));
            assign done_next[gi] = !flush && !clr_hit && (set_hit || done_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_reg <= '0;
        end else begin
            done_reg <= done_next;
        end
    end

    assign done = done_reg;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/status controller: in-order dual allocate, per-entry
// done tracking, and dual in-order retire from the head via the ROB RAM.
module rob_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter int WIDTH = ROB_WIDTH,
    parameter int ADDR  = ROB_ADDR,
    parameter int DEPTH = 1 << ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_req_0,
    input  logic             disp_req_1,
    output logic             disp_grant_0,
    output logic             disp_grant_1,
    output logic [ADDR-1:0]  disp_tag_0,
    output logic [ADDR-1:0]  disp_tag_1,
    input  logic             wb_valid_0,
    input  logic             wb_valid_1,
    input  logic [ADDR-1:0]  wb_tag_0,
    input  logic [ADDR-1:0]  wb_tag_1,
    output logic [ADDR-1:0]  ram_addr_out_0,
    output logic [ADDR-1:0]  ram_addr_out_1,
    output logic             ram_o_en_0,
    output logic             ram_o_en_1,
    input  logic [WIDTH-1:0] ram_data_0,
    input  logic [WIDTH-1:0] ram_data_1,
    input  logic             retire_en,
    output logic             commit_valid_0,
    output logic             commit_valid_1,
    output logic [4:0]       commit_rd_0,
    output logic [4:0]       commit_rd_1,
    output logic [31:0]      commit_value_0,
    output logic [31:0]      commit_value_1,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             empty
);

    logic [ADDR-1:0]  head_reg, head_next, head_p1;
    logic [ADDR-1:0]  tail_reg, tail_next, tail_p1;
    logic [ADDR:0]    count_reg, count_next, free;
    logic [1:0]       n_alloc, n_commit;
    logic [DEPTH-1:0] done_vec;
    logic             wb_ok_0, wb_ok_1;
    logic             unused_ram_done;

    assign head_p1 = head_reg + ADDR'(1);
    assign tail_p1 = tail_reg + ADDR'(1);
    // Free space ignores same-cycle commits so a retiring slot is never reused in that cycle.
    assign free    = (ADDR+1)'(DEPTH) - count_reg;

    assign disp_grant_0 = reset && disp_req_0 && (free >= (ADDR+1)'(1)) && !flush;
    assign disp_grant_1 = disp_req_1 && disp_grant_0 && (free >= (ADDR+1)'(2));
    assign disp_tag_0   = tail_reg;
    assign disp_tag_1   = tail_p1;

    assign commit_valid_0 = reset && retire_en && !flush &&
                            (count_reg >= (ADDR+1)'(1)) && done_vec[head_reg];
    assign commit_valid_1 = commit_valid_0 && (count_reg >= (ADDR+1)'(2)) && done_vec[head_p1];

    // Writebacks only count when the tag lies within [head, head+count).
    assign wb_ok_0 = wb_valid_0 && ({1'b0, wb_tag_0 - head_reg} < count_reg);
    assign wb_ok_1 = wb_valid_1 && ({1'b0, wb_tag_1 - head_reg} < count_reg);

    assign n_alloc  = {1'b0, disp_grant_0} + {1'b0, disp_grant_1};
    assign n_commit = {1'b0, commit_valid_0} + {1'b0, commit_valid_1};

    always_comb begin
        head_next  = head_reg + ADDR'(n_commit);
        tail_next  = tail_reg + ADDR'(n_alloc);
        count_next = count_reg + (ADDR+1)'(n_alloc) - (ADDR+1)'(n_commit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    rob_done_vec #(
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) u_done_vec (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .set_en     ({wb_ok_1, wb_ok_0}),
        .set_idx    ({wb_tag_1, wb_tag_0}),
        .alloc_en   ({disp_grant_1, disp_grant_0}),
        .alloc_idx  ({tail_p1, tail_reg}),
        .commit_en  ({commit_valid_1, commit_valid_0}),
        .commit_idx ({head_p1, head_reg}),
        .done       (done_vec)
    );

    assign ram_addr_out_0 = head_reg;
    assign ram_addr_out_1 = head_p1;
    assign ram_o_en_0     = reset;
    assign ram_o_en_1     = reset;

    assign commit_rd_0    = ram_data_0[ROB_RD_LSB +: 5];
    assign commit_rd_1    = ram_data_1[ROB_RD_LSB +: 5];
    assign commit_value_0 = ram_data_0[ROB_VAL_LSB +: 32];
    assign commit_value_1 = ram_data_1[ROB_VAL_LSB +: 32];
    // The RAM copy of done is not authoritative; the done vector is.
    assign unused_ram_done = ram_data_0[ROB_DONE_BIT] ^ ram_data_1[ROB_DONE_BIT];

    assign count = count_reg;
    assign full  = (count_reg == (ADDR+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule
